// File: rtl/line_conv2d_engine_v2.sv
// line_conv2d_engine_v2: KERNEL_W-tap sliding-window conv along one line for NUM_KERNEL kernels,
// with weight load/reuse, optional psum accumulation and output back-pressure.
module line_conv2d_engine_v2 #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int KERNEL_W    = 3,
    parameter int ACC_WIDTH   = 32,
    parameter int LEN_WIDTH   = 10
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_start,
    input  logic [LEN_WIDTH-1:0]                    cfg_line_len,
    input  logic                                    cfg_keep_w,
    input  logic                                    cfg_psum_en,
    input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight,
    input  logic                                    i_weight_val,
    output logic                                    o_weight_rdy,
    input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]        i_data,
    input  logic                                    i_data_val,
    output logic                                    o_data_rdy,
    input  logic [ACC_WIDTH*NUM_KERNEL-1:0]         i_psum,
    input  logic                                    i_psum_val,
    output logic [ACC_WIDTH*NUM_KERNEL-1:0]         o_psum,
    output logic                                    o_psum_val,
    input  logic                                    i_psum_rdy,
    output logic                                    o_busy,
    output logic                                    o_done,
    output logic                                    o_err
);
    localparam int B  = BIT_WIDTH;
    localparam int C  = NUM_CHANNEL;
    localparam int A  = ACC_WIDTH;
    localparam int DW = B * C;
    localparam int WW = B * C * NUM_KERNEL;
    localparam int PW = A * NUM_KERNEL;
    localparam int CW = $clog2(KERNEL_W);
    localparam logic [LEN_WIDTH-1:0] KW  = LEN_WIDTH'(KERNEL_W);
    localparam logic [LEN_WIDTH-1:0] KM1 = LEN_WIDTH'(KERNEL_W - 1);
    localparam logic [CW-1:0]        WLAST = CW'(KERNEL_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DRAIN} state_t;
    state_t state;

    logic [LEN_WIDTH-1:0] len, col;
    logic                 psum_en;
    logic [CW-1:0]        wcnt;
    logic [DW-1:0]        win [KERNEL_W];
    logic [WW-1:0]        w   [KERNEL_W];
    logic                 c_val, s1_val;
    logic [PW-1:0]        c_psum, s1_sum, s1_psum, dot, sum2;
    logic signed [2*B-1:0] prod;
    logic                 en, d_fire, w_fire;

    assign en         = !o_psum_val | i_psum_rdy;
    assign o_data_rdy = (state == RUN) & en & (col < len) & (!psum_en | i_psum_val | (col < KM1));
    assign d_fire     = o_data_rdy & i_data_val;
    assign w_fire     = o_weight_rdy & i_weight_val;
    assign o_busy     = state != IDLE;

    // win[0] is the oldest column and meets tap 0
    always_comb begin
        dot  = '0;
        prod = '0;
        for (int k = 0; k < NUM_KERNEL; k++)
            for (int t = 0; t < KERNEL_W; t++)
                for (int c = 0; c < C; c++) begin
                    prod = $signed(win[t][c*B +: B]) * $signed(w[t][(k*C+c)*B +: B]);
                    dot[k*A +: A] = dot[k*A +: A] + {{(A-2*B){prod[2*B-1]}}, prod};
                end
    end

    always_comb begin
        sum2 = '0;
        for (int k = 0; k < NUM_KERNEL; k++)
            sum2[k*A +: A] = s1_sum[k*A +: A] + s1_psum[k*A +: A];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            len          <= '0;
            col          <= '0;
            psum_en      <= 1'b0;
            wcnt         <= '0;
            o_weight_rdy <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            c_val        <= 1'b0;
            s1_val       <= 1'b0;
            o_psum_val   <= 1'b0;
            c_psum       <= '0;
            s1_sum       <= '0;
            s1_psum      <= '0;
            o_psum       <= '0;
            for (int t = 0; t < KERNEL_W; t++) begin
                win[t] <= '0;
                w[t]   <= '0;
            end
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    if (cfg_line_len < KW) o_err <= 1'b1;
                    else begin
                        len          <= cfg_line_len;
                        psum_en      <= cfg_psum_en;
                        col          <= '0;
                        o_weight_rdy <= !cfg_keep_w;
                        state        <= cfg_keep_w ? RUN : LOAD_W;
                    end
                end
                LOAD_W: if (w_fire) begin
                    w[wcnt] <= i_weight;
                    wcnt    <= (wcnt == WLAST) ? '0 : wcnt + 1'b1;
                    if (wcnt == WLAST) begin
                        o_weight_rdy <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: if (d_fire) begin
                    for (int t = 0; t < KERNEL_W - 1; t++) win[t] <= win[t+1];
                    win[KERNEL_W-1] <= i_data;
                    col <= col + 1'b1;
                    if (col + 1'b1 == len) state <= DRAIN;
                end
                DRAIN: if (!c_val && !s1_val && !o_psum_val) begin
                    state  <= IDLE;
                    o_done <= 1'b1;
                    col    <= '0;
                    for (int t = 0; t < KERNEL_W; t++) win[t] <= '0;
                end
                default: state <= IDLE;
            endcase
            // c_val marks a completing beat now sitting in the window; stage 1 reads it next cycle
            if (en) begin
                c_val <= d_fire & (col >= KM1);
                if (d_fire && col >= KM1) c_psum <= psum_en ? i_psum : '0;
                s1_val     <= c_val;
                s1_sum     <= dot;
                s1_psum    <= c_psum;
                o_psum_val <= s1_val;
                if (s1_val) o_psum <= sum2;
            end
        end
    end
endmodule

// File: tb/tb_line_conv2d_engine_v2.sv
// tb_line_conv2d_engine_v2: directed scenarios with hand-computed results for line_conv2d_engine_v2.
module tb_line_conv2d_engine_v2;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_start = 1'b0;
    logic [9:0]   cfg_line_len = '0;
    logic         cfg_keep_w = 1'b0;
    logic         cfg_psum_en = 1'b0;
    logic [95:0]  i_weight = '0;
    logic         i_weight_val = 1'b0;
    logic         o_weight_rdy;
    logic [23:0]  i_data = '0;
    logic         i_data_val = 1'b0;
    logic         o_data_rdy;
    logic [127:0] i_psum = '0;
    logic         i_psum_val = 1'b0;
    logic [127:0] o_psum;
    logic         o_psum_val;
    logic         i_psum_rdy = 1'b1;
    logic         o_busy, o_done, o_err;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit wrdy_seen = 0;
    bit busy_seen = 0;
    logic [127:0] q [$];

    line_conv2d_engine_v2 dut (
        .clk(clk), .rst(rst), .i_start(i_start), .cfg_line_len(cfg_line_len),
        .cfg_keep_w(cfg_keep_w), .cfg_psum_en(cfg_psum_en),
        .i_weight(i_weight), .i_weight_val(i_weight_val), .o_weight_rdy(o_weight_rdy),
        .i_data(i_data), .i_data_val(i_data_val), .o_data_rdy(o_data_rdy),
        .i_psum(i_psum), .i_psum_val(i_psum_val), .o_psum(o_psum), .o_psum_val(o_psum_val),
        .i_psum_rdy(i_psum_rdy), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_psum_val && i_psum_rdy) q.push_back(o_psum);
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
        if (o_weight_rdy) wrdy_seen = 1;
        if (o_busy) busy_seen = 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic start(input int len, input bit keep, input bit pen);
        cfg_line_len = 10'(len);
        cfg_keep_w = keep;
        cfg_psum_en = pen;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic load_w(input logic [7:0] wv);
        int g;
        bit acc;
        for (int t = 0; t < 3; t++) begin
            i_weight = {12{wv}};
            i_weight_val = 1'b1;
            g = 0;
            acc = 0;
            while (!acc && g < 200) begin
                @(negedge clk); acc = o_weight_rdy;
                @(posedge clk); #1; g++;
            end
            if (!acc) begin
                n_checks++; n_fail++;
                $display("FAIL weight_timeout tap %0d: o_weight_rdy got 0, expected 1", t);
            end
        end
        i_weight_val = 1'b0;
    endtask

    task automatic feed(input int n, input int v0, input int inc);
        int g;
        bit acc;
        for (int j = 0; j < n; j++) begin
            i_data = {3{8'(v0 + inc * j)}};
            i_data_val = 1'b1;
            g = 0;
            acc = 0;
            while (!acc && g < 200) begin
                @(negedge clk); acc = o_data_rdy;
                @(posedge clk); #1; g++;
            end
            if (!acc) begin
                n_checks++; n_fail++;
                $display("FAIL data_timeout beat %0d: o_data_rdy got 0, expected 1", j);
            end
        end
        i_data_val = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (o_busy && g < 300) begin
            @(posedge clk); #1; g++;
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: o_busy got %b, expected 0", o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_weight_rdy, o_data_rdy, o_psum_val, o_busy, o_done, o_err} !== 6'b0 || o_psum !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: flags %b psum %h, expected all 0",
                     {o_weight_rdy, o_data_rdy, o_psum_val, o_busy, o_done, o_err}, o_psum);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (o_busy !== 1'b0 || o_weight_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_idle: busy %b wrdy %b, expected 0 0", o_busy, o_weight_rdy);
        end
    endtask

    task automatic test_basic();
        int d0;
        logic [127:0] exp [3];
        exp = '{{4{32'd18}}, {4{32'd27}}, {4{32'd36}}};
        q.delete();
        d0 = done_cnt;
        start(5, 0, 0);
        n_checks++;
        if (o_weight_rdy !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_load_state: wrdy %b busy %b, expected 1 1", o_weight_rdy, o_busy);
        end
        load_w(8'h01);
        feed(5, 1, 1);
        wait_idle();
        n_checks++;
        if (q.size() !== 3) begin
            n_fail++;
            $display("FAIL basic_count: got %0d results, expected 3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= q.size() || q[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got %h, expected %h", i, q[i], exp[i]);
            end
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses, expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_keep_psum();
        int d0;
        logic [127:0] exp [3];
        exp = '{{4{32'd118}}, {4{32'd127}}, {4{32'd136}}};
        q.delete();
        d0 = done_cnt;
        i_psum = {4{32'd100}};
        i_psum_val = 1'b1;
        wrdy_seen = 0;
        start(5, 1, 1);
        feed(5, 1, 1);
        wait_idle();
        i_psum_val = 1'b0;
        n_checks++;
        if (q.size() !== 3) begin
            n_fail++;
            $display("FAIL psum_count: got %0d results, expected 3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= q.size() || q[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL psum_result[%0d]: got %h, expected %h", i, q[i], exp[i]);
            end
        end
        n_checks++;
        if (wrdy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL keep_no_weight: o_weight_rdy seen %b, expected 0", wrdy_seen);
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL psum_done: got %0d pulses, expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_pressure();
        logic [127:0] exp [3];
        exp = '{{4{32'd18}}, {4{32'd27}}, {4{32'd36}}};
        q.delete();
        i_psum_rdy = 1'b0;
        start(5, 1, 0);
        fork
            feed(5, 1, 1);
            begin
                int g = 0;
                while (!o_psum_val && g < 200) begin
                    @(negedge clk); g++;
                end
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    n_checks++;
                    if (o_psum_val !== 1'b1 || o_psum !== {4{32'd18}} || o_data_rdy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_hold[%0d]: val %b psum %h drdy %b, expected 1 %h 0",
                                 s, o_psum_val, o_psum, o_data_rdy, {4{32'd18}});
                    end
                end
                @(posedge clk); #1;
                i_psum_rdy = 1'b1;
            end
        join
        wait_idle();
        n_checks++;
        if (q.size() !== 3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, expected 3", q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= q.size() || q[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL stall_result[%0d]: got %h, expected %h", i, q[i], exp[i]);
            end
        end
    endtask

    task automatic test_negative();
        q.delete();
        start(3, 0, 0);
        load_w(8'hFF);
        feed(3, 127, 0);
        wait_idle();
        n_checks++;
        if (q.size() !== 1 || q[0] !== {4{32'hFFFFFB89}}) begin
            n_fail++;
            $display("FAIL negative_result: got %0d results first %h, expected 1 x %h",
                     q.size(), q[0], {4{32'hFFFFFB89}});
        end
    endtask

    task automatic test_err();
        int e0;
        e0 = err_cnt;
        wrdy_seen = 0;
        busy_seen = 0;
        start(2, 0, 0);
        n_checks++;
        if (o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_pulse: o_err got %b, expected 1", o_err);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_err !== 1'b0 || err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL err_single: o_err %b pulses %0d, expected 0 1", o_err, err_cnt - e0);
        end
        n_checks++;
        if (busy_seen !== 1'b0 || wrdy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL err_idle: busy seen %b wrdy seen %b, expected 0 0", busy_seen, wrdy_seen);
        end
    endtask

    task automatic test_reset_mid_run();
        start(5, 1, 0);
        feed(4, 127, 0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b1 || o_psum !== {4{32'hFFFFFB89}}) begin
            n_fail++;
            $display("FAIL mid_run_state: busy %b psum %h, expected 1 %h", o_busy, o_psum, {4{32'hFFFFFB89}});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({o_weight_rdy, o_data_rdy, o_psum_val, o_busy, o_done, o_err} !== 6'b0 || o_psum !== '0) begin
            n_fail++;
            $display("FAIL mid_run_reset: flags %b psum %h, expected all 0",
                     {o_weight_rdy, o_data_rdy, o_psum_val, o_busy, o_done, o_err}, o_psum);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        start(3, 1, 0);
        feed(3, 5, 0);
        wait_idle();
        n_checks++;
        if (q.size() !== 1 || q[0] !== '0) begin
            n_fail++;
            $display("FAIL cleared_weights: got %0d results first %h, expected 1 x 0", q.size(), q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_keep_psum();
        test_back_pressure();
        test_negative();
        test_err();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/line_conv2d_engine_v2.md
Name: line_conv2d_engine_v2

Overview:
Parametrised successor of the 3-position line kernel-channel conv engine. It computes a 1-D sliding-window convolution along one image line for NUM_CHANNEL input channels and NUM_KERNEL kernels, with KERNEL_W taps. The block has a weight-load phase, optional weight reuse, optional psum accumulation, and valid/ready back-pressure on the output. It sits between the line/weight buffers and the psum router of the conv datapath.

Parameters:
BIT_WIDTH, 8, signed data/weight width
NUM_CHANNEL, 3, input channels per beat
NUM_KERNEL, 4, kernels computed in parallel
KERNEL_W, 3, taps per window (>=2)
ACC_WIDTH, 32, signed accumulator/psum width
LEN_WIDTH, 10, width of line-length config

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
i_start  in  1  start pulse, accepted in IDLE only
cfg_line_len  in  LEN_WIDTH  data beats per line, sampled at i_start
cfg_keep_w  in  1  1 = skip weight load and reuse stored weights; sampled at i_start
cfg_psum_en  in  1  1 = add i_psum to each output; sampled at i_start
i_weight  in  BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL  one tap; kernel k, channel c at [(k*NUM_CHANNEL+c)*BIT_WIDTH +: BIT_WIDTH]
i_weight_val  in  1  weight beat valid
o_weight_rdy  out  1  weight beat ready
i_data  in  BIT_WIDTH*NUM_CHANNEL  one column; channel c at [c*BIT_WIDTH +: BIT_WIDTH]
i_data_val  in  1  data beat valid
o_data_rdy  out  1  data beat ready
i_psum  in  ACC_WIDTH*NUM_KERNEL  incoming psum, kernel k at [k*ACC_WIDTH +: ACC_WIDTH]
i_psum_val  in  1  psum valid
o_psum  out  ACC_WIDTH*NUM_KERNEL  result, same packing as i_psum
o_psum_val  out  1  result valid
i_psum_rdy  in  1  downstream ready
o_busy  out  1  state != IDLE
o_done  out  1  1-cycle pulse at end of line
o_err  out  1  1-cycle pulse on illegal start

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0. Window, weight store, counters and pipeline all cleared. A reset during any state aborts the operation with no further outputs.
- States: IDLE, LOAD_W, RUN, DRAIN.
- IDLE:
  - i_start with cfg_line_len < KERNEL_W: o_err pulse next cycle, stay IDLE.
  - Otherwise latch cfg. Go to RUN if cfg_keep_w=1, else LOAD_W.
- LOAD_W:
  - o_weight_rdy=1. A beat is accepted when i_weight_val=1 and o_weight_rdy=1.
  - Beat n is stored as tap n, for n = 0..KERNEL_W-1.
  - After KERNEL_W beats: o_weight_rdy=0 and go to RUN.
- RUN:
  - Define en = !o_psum_val | i_psum_rdy.
  - o_data_rdy = en & (col < len) & (!psum_en | i_psum_val | col < KERNEL_W-1).
  - An accepted data beat shifts the window and increments col.
  - Tap 0 multiplies the oldest column in the window; tap KERNEL_W-1 multiplies the newest.
  - A completing beat is any beat with col >= KERNEL_W-1. It launches a result. When psum_en=1, i_psum is captured with that beat; i_psum is ignored on non-completing beats.
  - When col reaches len: go to DRAIN.
- Pipeline: two stages, both advancing only when en=1.
  - Stage 1 registers, per kernel, the sum over taps and channels of signed data*weight. Each product is 2*BIT_WIDTH bits, sign-extended to ACC_WIDTH.
  - Stage 2 adds the captured psum (0 if psum_en=0) and loads o_psum/o_psum_val.
  - Arithmetic wraps modulo 2^ACC_WIDTH.
  - Latency: a completing beat accepted at edge t gives o_psum_val=1 after edge t+2 when no stall occurs.
  - While o_psum_val=1 and i_psum_rdy=0, o_psum holds stable and no beats are accepted.
- Each line produces exactly len-KERNEL_W+1 results.
- DRAIN: when both stages are empty (last result accepted), o_done pulses for 1 cycle and the block goes to IDLE. The weight store is kept. The window and col are cleared.
- Simultaneous o_psum accept and new stage-1 result in the same cycle: the output updates with no bubble.
- i_start outside IDLE is ignored.

Test Plan:
- Load weights all 1. cfg_line_len=5, psum_en=0. Data beat j has every channel = j+1 -> 3 results for all 4 kernels: 18, 27, 36. Then o_done pulses and o_busy falls.
- Same as above with cfg_keep_w=1 and psum_en=1, i_psum=100 for all kernels -> results 118, 127, 136, and no weight beats requested (o_weight_rdy stays 0).
- Hold i_psum_rdy=0 for 5 cycles after the first result -> o_psum stays at 18 and o_data_rdy=0. After release, 27 and 36 follow with nothing lost or duplicated.
- Weights 0xFF (-1), data 127 on all channels, cfg_line_len=3 -> one result 0xFFFFFB89 (-1143) per kernel.
- i_start with cfg_line_len=2 -> o_err pulse, o_busy stays 0, o_weight_rdy stays 0.
- Assert rst=0 mid-RUN -> all outputs 0 immediately. Then start with cfg_keep_w=1 and data 5 -> results 0, since weights were cleared.
